// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM/probability types, mask constants
// and LFSR helpers for the lfsr_rnd_sched random-bit scheduler.
`ifndef RNDSIZE
`define RNDSIZE 5
`endif

package lfsr_pkg;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    IDLE     = 2'd1,
    RESP     = 2'd2
  } state_t;

  typedef logic [1:0] prob_t;

  localparam int LFSR_W = `RNDSIZE * (`RNDSIZE - 1) / 2;
  localparam int MAX_W  = 64;

  localparam logic [9:0] MASK_05 = 10'h1FF;
  localparam logic [9:0] MASK_07 = 10'h2BB;
  localparam logic [9:0] MASK_08 = 10'h333;
  localparam logic [9:0] MASK_09 = 10'h3FF;

  // Base pattern left-aligned to a w-bit word; caller truncates.
  function automatic logic [MAX_W-1:0] mask_w(
    input prob_t c,
    input int    w
  );
    logic [9:0] b;
    unique case (c)
      2'b00:   b = MASK_05;
      2'b01:   b = MASK_07;
      2'b10:   b = MASK_08;
      default: b = MASK_09;
    endcase
    return {{(MAX_W-10){1'b0}}, b} << (w - 9);
  endfunction

  function automatic logic tap(
    input logic msb,
    input logic b3,
    input logic b2,
    input logic b0
  );
    return msb ^ b3 ^ b2 ^ b0;
  endfunction

endpackage

// File: rtl/lfsr_rnd_sched_arb.sv
// rr_arbiter: one-hot round-robin arbiter with internal pointer.
// Ports: req_i requests, adv_i grant taken; gnt_o/idx_o/any_o result.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] j;

  // First set request searching upward from ptr_q, wrapping.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_q) + i) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && any_o)
      ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lfsr_rnd_sched_lfsr_comb.sv
// LFSR_comb: one combinational LFSR step plus probability mask.
// Ports: seed_i/prob_i in; next_o (shifted state), rnd_o (masked word).
module LFSR_comb
  import lfsr_pkg::*;
#(
  parameter int W = LFSR_W
) (
  input  logic [W-1:0] seed_i,
  input  prob_t        prob_i,
  output logic [W-1:0] next_o,
  output logic [W-1:0] rnd_o
);

  logic [W-1:0] mask;

  assign mask   = W'(mask_w(prob_i, W));
  assign next_o = {seed_i[W-2:0],
                   tap(seed_i[W-1], seed_i[3],
                       seed_i[2], seed_i[0])};
  assign rnd_o  = next_o ^ mask;

endmodule

// File: rtl/lfsr_rnd_sched.sv
// lfsr_rnd_sched: seed owner + round-robin sharing of one LFSR_comb.
// Ports: seed_load/seed_in/seed_err/seeded, req_valid/req_prob/req_ready,
// rsp_valid/rsp_ready/rsp_id/rsp_data; step_cnt with LFSR_STEP_CNT_EN.
module lfsr_rnd_sched
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = LFSR_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load,
  input  logic [W-1:0]         seed_in,
  output logic                 seed_err,
  output logic                 seeded,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_prob,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_data
`ifdef LFSR_STEP_CNT_EN
  ,
  output logic [31:0]          step_cnt
`endif
);

  state_t              state_q;
  logic [W-1:0]        seed_q;
  logic                seeded_q;
  logic                seed_err_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [W-1:0]        rsp_data_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     win;
  logic                any_req;
  logic                grant_fire;
  logic                load_ok;
  logic                load_zero;
  logic                seed_zero;
  prob_t               win_prob;
  logic [W-1:0]        lfsr_next;
  logic [W-1:0]        lfsr_rnd;

  assign load_ok    = seed_load & (|seed_in);
  assign load_zero  = seed_load & ~(|seed_in);
  assign seed_zero  = ~(|seed_q);

  // A seed load in IDLE takes the cycle; no grant alongside it.
  assign grant_fire = (state_q == IDLE) & ~seed_load
                    & ~seed_zero & any_req;

  assign req_ready  = grant_fire ? gnt : '0;
  assign win_prob   = req_prob[{win, 1'b0} +: 2];

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .adv_i (grant_fire),
    .gnt_o (gnt),
    .idx_o (win),
    .any_o (any_req)
  );

  LFSR_comb #(
    .W (W)
  ) u_lfsr (
    .seed_i (seed_q),
    .prob_i (win_prob),
    .next_o (lfsr_next),
    .rnd_o  (lfsr_rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNSEEDED;
      seed_q      <= '0;
      seeded_q    <= 1'b0;
      seed_err_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      seed_err_q <= load_zero;
      if (load_ok)
        seed_q <= seed_in;
      unique case (state_q)
        UNSEEDED: begin
          if (load_ok) begin
            seeded_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        IDLE: begin
          if (!seed_load && seed_zero) begin
            seeded_q <= 1'b0;
            state_q  <= UNSEEDED;
          end else if (grant_fire) begin
            rsp_data_q  <= lfsr_rnd;
            rsp_id_q    <= win;
            // The mask is not fed back: the state walks the pure LFSR.
            seed_q      <= lfsr_next;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (!load_ok && seed_zero) begin
            seeded_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            state_q     <= UNSEEDED;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= UNSEEDED;
        end
      endcase
    end
  end

  assign seed_err  = seed_err_q;
  assign seeded    = seeded_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef LFSR_STEP_CNT_EN
  logic [31:0] step_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step_cnt_q <= '0;
    else if (load_ok)
      step_cnt_q <= '0;
    else if (rsp_valid_q && rsp_ready && (step_cnt_q != '1))
      step_cnt_q <= step_cnt_q + 32'd1;
  end

  assign step_cnt = step_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_rnd_sched.sv
// tb_lfsr_rnd_sched: scoreboard bench for lfsr_rnd_sched
// with a behavioural reference model (NUM_REQ=4, W=10).
module tb_lfsr_rnd_sched;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           seed_load = 1'b0;
  logic [W-1:0]   seed_in = '0;
  logic           seed_err;
  logic           seeded;
  logic [N-1:0]   req_valid = '0;
  logic [2*N-1:0] req_prob = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;
`ifdef LFSR_STEP_CNT_EN
  logic [31:0]    step_cnt;
`endif

  lfsr_rnd_sched #(
    .NUM_REQ (N),
    .W       (W),
    .ID_W    (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .seed_err  (seed_err),
    .seeded    (seeded),
    .req_valid (req_valid),
    .req_prob  (req_prob),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef LFSR_STEP_CNT_EN
    ,
    .step_cnt  (step_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_seeded = 0;
  bit          m_busy = 0;
  bit          m_err = 0;
  logic [W-1:0] m_seed = '0;
  int          m_ptr = 0;
  logic [31:0] m_cnt = '0;
  logic [N-1:0] m_last_gnt = '0;
  rsp_t        sb_q[$];
  logic [W-1:0] const_q[$];
  bit          done = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [W-1:0] ref_step(input logic [W-1:0] s);
    longint v, par;
    v   = longint'(s);
    par = ((v >> (W - 1)) ^ (v >> 3) ^ (v >> 2) ^ v) & 64'd1;
    return W'((v * 2 + par) % (64'd1 << W));
  endfunction

  function automatic logic [W-1:0] ref_mask(input logic [1:0] c);
    longint base [4];
    base = '{64'h1FF, 64'h2BB, 64'h333, 64'h3FF};
    return W'((base[c] * (64'd1 << (W - 9))) % (64'd1 << W));
  endfunction

  function automatic int ref_win(input logic [N-1:0] rq);
    if (!m_seeded || m_busy || seed_load) return -1;
    for (int k = 0; k < N; k++)
      if (rq[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] ref_gnt(input logic [N-1:0] rq);
    int w;
    w = ref_win(rq);
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  // Model: advances on each clock from the bench's own inputs.
  initial begin
    int   mw;
    bit   mb0, mload;
    rsp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_seeded = 0; m_busy = 0; m_err = 0;
        m_seed = '0; m_ptr = 0; m_cnt = '0;
        m_last_gnt = '0;
        sb_q.delete();
      end else begin
        mb0   = m_busy;
        mw    = ref_win(req_valid);
        mload = seed_load && (seed_in != '0);
        m_err = seed_load && (seed_in == '0);
        m_last_gnt = '0;
        if (mload) begin
          m_seed = seed_in; m_seeded = 1; m_cnt = '0;
        end
        if (mb0 && rsp_ready) begin
          m_busy = 0;
          if (!mload && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        if (mw >= 0) begin
          e.id   = IW'(mw);
          e.data = ref_step(m_seed) ^ ref_mask(req_prob[2*mw +: 2]);
          sb_q.push_back(e);
          m_seed = ref_step(m_seed);
          m_ptr  = (mw + 1) % N;
          m_busy = 1;
          m_last_gnt = N'(1) << mw;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    rsp_t e, h;
    logic pv;
    logic [W-1:0] cexp;
    pv = 0;
    h.id = '0; h.data = '0;
    while (!done) begin
      @(negedge clk); #2;
      if (done) break;
      if (!rst_n) begin
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_seeded", 64'(seeded), 64'd0);
        check("rst_seed_err", 64'(seed_err), 64'd0);
        pv = 0;
        continue;
      end
      check("req_ready", 64'(req_ready), 64'(ref_gnt(req_valid)));
      check("rsp_valid", 64'(rsp_valid), 64'(m_busy));
      check("seed_err", 64'(seed_err), 64'(m_err));
      check("seeded", 64'(seeded), 64'(m_seeded));
`ifdef LFSR_STEP_CNT_EN
      check("step_cnt", 64'(step_cnt), 64'(m_cnt));
`endif
      if (rsp_valid === 1'b1) begin
        if (!pv) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: got id %0d data %0h want none",
                     rsp_id, rsp_data);
          end else begin
            e = sb_q.pop_front();
            h = e;
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_data", 64'(rsp_data), 64'(e.data));
            if (const_q.size() != 0) begin
              cexp = const_q.pop_front();
              check("rsp_data_const", 64'(rsp_data), 64'(cexp));
            end
          end
        end else begin
          check("hold_id", 64'(rsp_id), 64'(h.id));
          check("hold_data", 64'(rsp_data), 64'(h.data));
        end
      end
      pv = rsp_valid;
    end
    check("sb_left", 64'(sb_q.size()), 64'd0);
    check("const_left", 64'(const_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Driver
  task automatic step();
    @(negedge clk);
    req_valid = req_valid & ~m_last_gnt;
    seed_load = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_prob[2*i +: 2] = 2'($urandom_range(0, 3));
        end
      rsp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) begin
        seed_load = 1'b1;
        seed_in   = W'($urandom_range(1, (1 << W) - 1));
      end
    end
  endtask

  initial begin
    int g;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // zero seed is rejected; requests stay ungranted
    step(); seed_load = 1'b1; seed_in = '0;
    step(); req_valid = '1;
    repeat (4) step();
    req_valid = '0;

    // directed values from seed 0x001
    step(); seed_load = 1'b1; seed_in = 10'h001;
    step(); req_valid = 4'b0001; req_prob = 8'h00; rsp_ready = 1'b1;
    const_q.push_back(10'h3FD);
    repeat (3) step();
    req_valid = 4'b0001; req_prob = 8'h01;
    const_q.push_back(10'h171);
    repeat (3) step();

    // round robin, all requesting
    req_prob = 8'($urandom);
    for (int c = 0; c < 12; c++) begin
      step(); req_valid = '1;
    end

    // backpressure
    rsp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step(); req_valid = '1;
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    repeat (3) step();

    // seed load and request together: load wins
    step(); seed_load = 1'b1; seed_in = 10'h155;
    req_valid = 4'b0010; req_prob = 8'b0000_1100;
    const_q.push_back(10'h154);
    repeat (4) step();

    rand_cycles(400);

    // reset in the middle of a held response
    seed_load = 1'b0;
    req_valid[0] = 1'b1;
    rsp_ready = 1'b0;
    g = 0;
    while (!m_busy && g < 20) begin
      step(); req_valid[0] = 1'b1; rsp_ready = 1'b0; g++;
    end
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step(); seed_load = 1'b1; seed_in = 10'h2A5;
    rand_cycles(60);

    step(); req_valid = '0; rsp_ready = 1'b1;
    repeat (4) step();
    done = 1;
  end

endmodule

// File: doc/lfsr_rnd_sched.md
Name: lfsr_rnd_sched

Overview:
Sequential owner of the random-bit datapath. Holds the seed register, steps one LFSR_comb instance per granted request, and shares that single generator between NUM_REQ requesters. Arbitration is round-robin, and each requester selects its own probability code. Sits between the circuit-evaluation front end (the requesters) and the combinational LFSR/mask datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, `RNDSIZE*(`RNDSIZE-1)/2, seed/random word width (must be >= 10)
ID_W, $clog2(NUM_REQ), requester index width

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
seed_load  in  1  load seed_in into seed register this cycle
seed_in  in  W  new seed value
seed_err  out  1  one-cycle pulse: seed_load with all-zero seed_in rejected
seeded  out  1  high once a valid seed has been loaded
req_valid  in  NUM_REQ  per-requester request; held until granted
req_prob  in  2*NUM_REQ  per-requester probability code, bits [2i+1:2i]; stable while req_valid
req_ready  out  NUM_REQ  one-hot grant pulse
rsp_valid  out  1  response holding
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  index of the requester served
rsp_data  out  W  masked random word

Behaviour:
- Reset (async assert, sync deassert by the top level): state UNSEEDED, seed_q=0, seeded=0, seed_err=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0.
- FSM states:
  - UNSEEDED: req_ready=0. A seed_load with nonzero seed_in sets seed_q=seed_in and seeded=1, then goes to IDLE.
  - IDLE: if seed_load is high, the load is handled and no grant is issued this cycle (the load wins). Otherwise, if any req_valid is set, the grant goes to the first set bit searching upward from rr_ptr with wrap. The block then:
    - pulses req_ready[win] for one cycle;
    - computes rnd = LFSR_comb(seed_q, req_prob[win]);
    - registers rsp_data=rnd and rsp_id=win;
    - sets seed_q = rnd ^ mask(req_prob[win]), which is the unmasked shifted state;
    - sets rr_ptr = (win+1) mod NUM_REQ;
    - goes to RESP.
  - RESP: rsp_valid=1; rsp_data and rsp_id stay stable. On rsp_ready, next cycle rsp_valid=0 and the state returns to IDLE.
- Timing: latency from req_valid to rsp_valid is 1 cycle. Peak throughput is one word per 2 cycles.
- LFSR step: next = {seed_q[W-2:0], seed_q[W-1]^seed_q[3]^seed_q[2]^seed_q[0]}.
- Masks, truncated to W bits: code 00 -> 10'h1FF<<(W-9); 01 -> 10'h2BB<<(W-9); 10 -> 10'h333<<(W-9); 11 -> 10'h3FF<<(W-9).
- seed_load with seed_in==0 in any state: ignored, seed_err pulses, state unchanged (this prevents all-zero lockup).
- seed_load with nonzero seed_in in RESP: updates seed_q. The held rsp_data is unaffected.
- If seed_q ever reaches 0, treat it as an internal error: state returns to UNSEEDED and seeded=0. This is unreachable with valid loads; it is kept as a guard.
- A requester whose req_valid drops before grant is simply skipped. No partial grant exists.
- Reset asserted mid-RESP: response is lost and all outputs return to reset values immediately.

Optional Feature:
LFSR_STEP_CNT_EN
- Defined: adds output step_cnt [31:0]. It increments on each completed rsp_valid&&rsp_ready, saturates at 32'hFFFF_FFFF, and clears on any accepted (nonzero) seed_load; it resets to 0.
- Undefined: no port and no counter logic.

Decomposition:
- Package lfsr_pkg holds: state enum typedef (UNSEEDED, IDLE, RESP); probability code typedef (2-bit); mask function/constants MASK_05/07/08/09 parameterised by W; tap function.
- Sub-module: LFSR_comb instanced unchanged as the datapath.
- Natural sub-module: rr_arbiter (NUM_REQ one-hot round-robin with pointer).

Test Plan:
- Sequence, with `RNDSIZE=5 (W=10), NUM_REQ=4:
  - seed_load 0x001, then req_valid=0001, prob 00 -> req_ready=0001 pulse; next cycle rsp_valid=1, rsp_data=0x3FD, rsp_id=0; seed_q=0x003.
  - Continue from seed 0x003, req 0 prob 01 -> rsp_data=0x171; seed_q=0x007.
- Round-robin: all req_valid=1111, rsp_ready=1 -> grant order 0,1,2,3,0. One grant every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_data/rsp_id stable, no req_ready pulses, seed_q unchanged.
- Zero seed: seed_load with seed_in=0 after reset -> seed_err pulse, seeded=0, requests never granted.
- Simultaneous seed_load 0x155 and request in IDLE -> no grant that cycle; grant next cycle using seed 0x155.
- With LFSR_STEP_CNT_EN: 3 accepted responses -> step_cnt=3; seed_load 0x001 -> step_cnt=0.
